// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, fixed-latency imem fetch, DEPTH-entry prefetch queue, HLT detection.
// Optional static backward-taken branch prediction when FETCH_BP_EN is defined.
`default_nettype none

module fetch_queue #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]  HLT_OP   = 4'hF,
  parameter logic [3:0]  BR_OP    = 4'hC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              dec_pred,
  output logic              hlt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CRED_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              cancel_q, cancel_d;
  logic [ADDR_W-1:0] ent_pc_q    [DEPTH];
  logic [ADDR_W-1:0] ent_pc_d    [DEPTH];
  logic [DATA_W-1:0] ent_instr_q [DEPTH];
  logic [DATA_W-1:0] ent_instr_d [DEPTH];
  logic              ent_pred_q  [DEPTH];
  logic              ent_pred_d  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halt_seen_q, halt_seen_d;
  logic              hlt_q, hlt_d;

  logic              issue, deq, hlt_xfer, wr_en, wr_pred, bp_taken;
  logic [ADDR_W-1:0] bp_target;
  logic [CRED_W-1:0] credit;
  logic [3:0]        rdata_op;

  // Credit covers both queued entries and the one return still on the bus.
  assign credit    = CRED_W'(count_q) + CRED_W'(inflight_q);
  assign issue     = !rst && !hlt_q && !halt_seen_q && !redirect && (credit < CRED_W'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign dec_valid = (count_q != '0) && !hlt_q && !redirect;
  assign dec_instr = ent_instr_q[rd_ptr_q];
  assign dec_pc    = ent_pc_q[rd_ptr_q];
  assign dec_pred  = ent_pred_q[rd_ptr_q];
  assign hlt       = hlt_q;

  assign deq      = dec_valid && dec_ready;
  assign hlt_xfer = deq && (ent_instr_q[rd_ptr_q][DATA_W-1 -: 4] == HLT_OP);
  assign wr_en    = inflight_q && !cancel_q && !redirect && !hlt_xfer;
  assign rdata_op = imem_rdata[DATA_W-1 -: 4];

`ifdef FETCH_BP_EN
  assign wr_pred   = (rdata_op == BR_OP) && imem_rdata[8];
  assign bp_taken  = wr_en && wr_pred;
  assign bp_target = inflight_pc_q + ADDR_W'(2) +
                     {{(ADDR_W-10){imem_rdata[8]}}, imem_rdata[8:0], 1'b0};
`else
  assign wr_pred   = 1'b0;
  assign bp_taken  = 1'b0;
  assign bp_target = pc_q;
`endif

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
    cancel_d      = issue && bp_taken;
    ent_pc_d      = ent_pc_q;
    ent_instr_d   = ent_instr_q;
    ent_pred_d    = ent_pred_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    halt_seen_d   = halt_seen_q;
    hlt_d         = hlt_q || hlt_xfer;

    if (issue)    pc_d = pc_q + ADDR_W'(2);
    if (bp_taken) pc_d = bp_target;

    if (wr_en) begin
      ent_pc_d[wr_ptr_q]    = inflight_pc_q;
      ent_instr_d[wr_ptr_q] = imem_rdata;
      ent_pred_d[wr_ptr_q]  = wr_pred;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      if (rdata_op == HLT_OP) halt_seen_d = 1'b1;
    end
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq);

    // Redirect and a taken HLT both discard everything queued or returning.
    if (redirect || hlt_xfer) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
    if (redirect) begin
      pc_d        = redirect_pc;
      halt_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      cancel_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
        ent_pred_q[i]  <= 1'b0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      halt_seen_q   <= 1'b0;
      hlt_q         <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      cancel_q      <= cancel_d;
      ent_pc_q      <= ent_pc_d;
      ent_instr_q   <= ent_instr_d;
      ent_pred_q    <= ent_pred_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halt_seen_q   <= halt_seen_d;
      hlt_q         <= hlt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue plus HLT and branch-prediction sequences.
`default_nettype none

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_pred;
  logic        hlt;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [0:32767];

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pred(dec_pred),
    .hlt(hlt)
  );

  always #5 clk = ~clk;

  // One-cycle latency instruction memory.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[15:1]];
    else          imem_rdata <= 16'hDEAD;
  end

  typedef struct {
    logic        rst, rdy, redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid, chk_dec;
    logic [15:0] pc, instr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic rd, input logic rdr, input logic [15:0] rp,
                              input logic rq, input logic [15:0] ad, input logic v, input logic cd,
                              input logic [15:0] p, input logic [15:0] ins);
    vec_t t;
    t.rst = r; t.rdy = rd; t.redir = rdr; t.rpc = rp; t.req = rq; t.addr = ad;
    t.valid = v; t.chk_dec = cd; t.pc = p; t.instr = ins;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic cyc(input logic r, input logic rd, input logic rdr, input logic [15:0] rp);
    @(negedge clk);
    rst = r; dec_ready = rd; redirect = rdr; redirect_pc = rp;
    #1;
  endtask

  logic        found;
  logic [15:0] exp_next_pc;
  logic        exp_pred;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i);

    cyc(1, 1, 0, 16'h0000);
    cyc(1, 1, 0, 16'h0000);

    //        rst rdy rdr rpc       req addr      vld cd pc        instr
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0002, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0000, 16'h1000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 1, 16'h0002, 16'h1001));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0008, 1, 1, 16'h0004, 16'h1002));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h000A, 1, 1, 16'h0006, 16'h1003));
    tv.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h000C, 1, 1, 16'h0008, 16'h1004));
    tv.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h000E, 1, 1, 16'h0008, 16'h1004));
    tv.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0010, 1, 1, 16'h0008, 16'h1004));
    tv.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0010, 1, 1, 16'h0008, 16'h1004));
    tv.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0010, 1, 1, 16'h0008, 16'h1004));
    tv.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0010, 1, 1, 16'h0008, 16'h1004));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0010, 1, 1, 16'h000A, 16'h1005));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0012, 1, 1, 16'h000C, 16'h1006));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0014, 1, 1, 16'h000E, 16'h1007));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0016, 1, 1, 16'h0010, 16'h1008));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0018, 1, 1, 16'h0012, 16'h1009));
    tv.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h001A, 1, 1, 16'h0014, 16'h100A));
    tv.push_back(mk(0, 1, 1, 16'h0040, 0, 16'h001C, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0042, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0044, 1, 1, 16'h0040, 16'h1020));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0046, 1, 1, 16'h0042, 16'h1021));
    tv.push_back(mk(0, 1, 1, 16'hFFFE, 0, 16'h0048, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'hFFFE, 16'h8FFF));
    tv.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0000, 16'h1000));

    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].rdy, tv[i].redir, tv[i].rpc);
      chk($sformatf("row%0d imem_req", i),  32'(imem_req),  32'(tv[i].req));
      chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tv[i].addr));
      chk($sformatf("row%0d dec_valid", i), 32'(dec_valid), 32'(tv[i].valid));
      chk($sformatf("row%0d hlt", i),       32'(hlt),       32'd0);
      if (tv[i].chk_dec) begin
        chk($sformatf("row%0d dec_pc", i),    32'(dec_pc),    32'(tv[i].pc));
        chk($sformatf("row%0d dec_instr", i), 32'(dec_instr), 32'(tv[i].instr));
        chk($sformatf("row%0d dec_pred", i),  32'(dec_pred),  32'd0);
      end
    end

    // HLT at 0x0004
    mem[2] = 16'hF000;
    cyc(1, 1, 0, 16'h0000);
    cyc(1, 1, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000);
    chk("hlt c0 req", 32'(imem_req), 32'd1);
    cyc(0, 1, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000);
    chk("hlt c2 pc", 32'(dec_pc), 32'h0000);
    cyc(0, 1, 0, 16'h0000);
    chk("hlt c3 req", 32'(imem_req), 32'd1);
    chk("hlt c3 addr", 32'(imem_addr), 32'h0006);
    cyc(0, 1, 0, 16'h0000);
    chk("hlt c4 req stopped", 32'(imem_req), 32'd0);
    chk("hlt c4 head", 32'(dec_instr), 32'hF000);
    chk("hlt c4 valid", 32'(dec_valid), 32'd1);
    chk("hlt c4 hlt low", 32'(hlt), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, 16'h0000);
      chk($sformatf("hlt c%0d hlt", k + 5), 32'(hlt), 32'd1);
      chk($sformatf("hlt c%0d valid", k + 5), 32'(dec_valid), 32'd0);
      chk($sformatf("hlt c%0d req", k + 5), 32'(imem_req), 32'd0);
    end
    cyc(1, 1, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000);
    chk("hlt cleared by rst", 32'(hlt), 32'd0);
    chk("restart req", 32'(imem_req), 32'd1);
    chk("restart addr", 32'(imem_addr), 32'h0000);
    mem[2] = 16'h1002;

    // Backward branch at 0x0010
    mem[8] = 16'hC1FE;
`ifdef FETCH_BP_EN
    exp_next_pc = 16'h000E;
    exp_pred    = 1'b1;
`else
    exp_next_pc = 16'h0012;
    exp_pred    = 1'b0;
`endif
    cyc(1, 1, 0, 16'h0000);
    cyc(1, 1, 0, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 1, 0, 16'h0000);
      if (dec_valid && dec_pc == 16'h0010) begin
        found = 1'b1;
        break;
      end
    end
    chk("br reached", 32'(found), 32'd1);
    chk("br instr", 32'(dec_instr), 32'hC1FE);
    chk("br pred", 32'(dec_pred), 32'(exp_pred));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, 16'h0000);
      if (dec_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("br next valid", 32'(found), 32'd1);
    chk("br next pc", 32'(dec_pc), 32'(exp_next_pc));
    chk("br next pred", 32'(dec_pred), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
